pipe_step_ctrl: RTL and testbench
=================================

# pipe_step_ctrl

Sequencing controller for the two-stage demo adder pipeline. It converts the raw push button into clean, single-cycle advance enables (`adv`) for the pipeline registers, which are clocked on `clk`, never on a derived clock. It supports four modes: manual single-step, free-running auto-step, N-step burst, and freeze. It also tracks per-stage valid flags and a step count so that the 7-segment/LED display logic can blank stages that hold no valid data.

## Interface
- DEBOUNCE_CYCLES, 1048575: consecutive stable samples required to accept a key level change.
- AUTO_DIV, 50000000: clk cycles between auto/burst advances (1 Hz at 50 MHz); must be ≥2.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- key_n  in  1  raw step push button, active-low (0 = pressed), asynchronous to clk.
- mode  in  2  00 manual, 01 auto, 10 burst, 11 freeze (from slide switches).
- burst_len  in  4  burst step count; 0 means 16.
- load_valid  in  1  the operand presented at the next advance is valid.
- adv  out  1  one-cycle pipeline register enable.
- v1  out  1  stage-1 registers hold valid data.
- v2  out  1  stage-2 register holds valid data.
- step_cnt  out  8  total advances since reset, wraps 255→0.
- busy  out  1  burst in progress.
- state  out  2  FSM state encoding, for LEDs.

## Operation
- Key path: 2-flop synchronizer, then debounce. The debounced level `db` flips only after the synchronized key differs from `db` for DEBOUNCE_CYCLES consecutive cycles; the counter clears on any sample equal to `db`. A press event is a 0→1 transition of `db` (pressed), registered as a one-cycle pulse `press`. Release is debounced identically but generates no event.
- FSM states: IDLE=0, AUTO=1, BURST=2, FROZEN=3.
  - IDLE, mode 00: `press` → `adv` for one cycle.
  - IDLE → AUTO when mode=01.
  - IDLE → FROZEN when mode=11.
  - IDLE, mode 10: `press` → BURST, loading `remaining` = burst_len (0→16).
  - AUTO: tick counter runs 0..AUTO_DIV-1; `adv` pulses when tick = AUTO_DIV-1, then tick wraps to 0. `press` is ignored. Mode ≠01 → IDLE.
  - BURST: same tick generator. Each `adv` decrements `remaining`. The `adv` with `remaining`=1 returns the FSM to IDLE. `press` is ignored. Mode ≠10 aborts to IDLE the next cycle with no further `adv`.
  - FROZEN: no `adv`; `press` is ignored. Mode ≠11 → IDLE.
- Tick counter is cleared to 0 on every entry into AUTO or BURST, so the first auto `adv` comes AUTO_DIV cycles after entry.
- On `adv`: v1 ← load_valid; v2 ← v1; step_cnt ← step_cnt+1. No `adv` → all three hold.
- `busy` = (state == BURST).
- A `press` arriving in the same cycle as a mode change is evaluated against the state current in that cycle.

## Timing
- Reset (rst=0, async) values:
  - outputs: adv=0, v1=0, v2=0, step_cnt=0, busy=0, state=IDLE.
  - internals: sync flops=1 (released), db=released, counters=0, remaining=0.
- Reset mid-burst aborts immediately; no `adv` is issued while rst=0 or in the first cycle after release.
- Manual latency: for a key_n fall sampled at edge 0 and held, `press` is high at edge 2+DEBOUNCE_CYCLES+1 and `adv` at the following edge (DEBOUNCE_CYCLES+4 total). All outputs are registered.
- Exactly one `adv` per press, regardless of hold time. Bounces shorter than DEBOUNCE_CYCLES produce no `adv`.
- `adv` is never high for two consecutive cycles in any mode, since AUTO_DIV ≥ 2.
- Burst of N yields exactly N `adv` pulses, spaced AUTO_DIV cycles apart, the first AUTO_DIV cycles after BURST entry.

## Structure
- Package `pipe_ctrl_pkg`:
  - mode constants MODE_MANUAL/AUTO/BURST/FREEZE.
  - FSM state encodings ST_IDLE/ST_AUTO/ST_BURST/ST_FROZEN.
  - counter width derivation from DEBOUNCE_CYCLES and AUTO_DIV.
- Sub-module `key_debounce` (sync + debounce + press pulse; parameter DEBOUNCE_CYCLES; ports clk, rst, key_n, press). It is reused for other demo buttons.
- Top holds the FSM, tick divider, burst counter, valid shift, and step counter.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, AUTO_DIV=5.
- Mode 00, key_n low for 20 cycles with 3-cycle bounces first → exactly one `adv`, 8 cycles after the stable low begins; step_cnt=1.
- Mode 00, load_valid=1, three presses → v1=1 after 1st `adv`, v2=1 after 2nd; then load_valid=0 and a press → v1=0, v2=1.
- Mode 01 for 26 cycles → `adv` at cycles 5, 10, 15, 20, 25 after entry; a press in between gives no extra `adv`.
- Mode 10, burst_len=3, one press → 3 `adv`s 5 cycles apart, busy high throughout, IDLE after; burst_len=0 gives 16.
- Mode 10, burst_len=8, switch to 11 after the 2nd `adv` → no further `adv`, state=FROZEN, busy=0.
- rst pulsed low mid-burst → all outputs return to reset values immediately; 255 steps then one more → step_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the demo pipeline step controller: mode switch
// codes, FSM state encodings and a counter-width helper.
package pipe_ctrl_pkg;

    // Slide-switch mode codes
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b10;
    localparam logic [1:0] MODE_FREEZE = 2'b11;

    // FSM state encodings, also shown on the LEDs
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_AUTO   = 2'd1;
    localparam logic [1:0] ST_BURST  = 2'd2;
    localparam logic [1:0] ST_FROZEN = 2'd3;

    // Bits needed for a counter that must reach max_val
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) return 1;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debounce and a
// one-cycle press pulse on each debounced released->pressed transition.
module key_debounce
    import pipe_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1048575
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int               CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db_n;
    logic             r_db_n_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw key into the clk domain; idles at released (1)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level once the synchronized key has disagreed with the
    // debounced level long enough; any agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_n <= 1'b1;
            r_cnt  <= '0;
        end else if (r_sync2 == r_db_n) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_db_n <= r_sync2;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // Registered edge detect: pulse only on released -> pressed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db_n_d <= 1'b1;
            r_press  <= 1'b0;
        end else begin
            r_db_n_d <= r_db_n;
            r_press  <= r_db_n_d & ~r_db_n;
        end
    end

    assign press = r_press;

endmodule

// File: rtl/pipe_step_ctrl.sv
// Sequencing controller for the two-stage demo adder pipeline: turns the
// step button and mode switches into single-cycle advance enables and
// tracks per-stage valid flags plus a running step count.
module pipe_step_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1048575,
    parameter int AUTO_DIV        = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic [1:0] mode,
    input  logic [3:0] burst_len,
    input  logic       load_valid,
    output logic       adv,
    output logic       v1,
    output logic       v2,
    output logic [7:0] step_cnt,
    output logic       busy,
    output logic [1:0] state
);

    localparam int                TICK_W    = cnt_width(AUTO_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_DIV - 1);

    logic              w_press;
    logic              w_tick_hit;
    logic [1:0]        w_state_nxt;
    logic              w_adv_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [4:0]        w_rem_nxt;

    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_adv;
    logic [TICK_W-1:0] r_tick;
    logic [4:0]        r_remaining;
    logic              r_v1;
    logic              r_v2;
    logic [7:0]        r_step_cnt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .press (w_press)
    );

    assign w_tick_hit = (r_tick == TICK_LAST);

    // Next-state logic; the tick counter sits at 0 in IDLE so every entry
    // into AUTO or BURST starts a full AUTO_DIV period
    always_comb begin
        w_state_nxt = r_state;
        w_adv_nxt   = 1'b0;
        w_tick_nxt  = r_tick;
        w_rem_nxt   = r_remaining;
        case (r_state)
            ST_IDLE: begin
                w_tick_nxt = '0;
                if (mode == MODE_AUTO) begin
                    w_state_nxt = ST_AUTO;
                end else if (mode == MODE_FREEZE) begin
                    w_state_nxt = ST_FROZEN;
                end else if (mode == MODE_MANUAL && w_press) begin
                    w_adv_nxt = 1'b1;
                end else if (mode == MODE_BURST && w_press) begin
                    w_state_nxt = ST_BURST;
                    w_rem_nxt   = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                end
            end
            ST_AUTO: begin
                if (mode != MODE_AUTO) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick_hit) begin
                    w_adv_nxt  = 1'b1;
                    w_tick_nxt = '0;
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
            ST_BURST: begin
                if (mode != MODE_BURST) begin
                    w_state_nxt = ST_IDLE;
                    w_rem_nxt   = '0;
                end else if (w_tick_hit) begin
                    w_adv_nxt  = 1'b1;
                    w_tick_nxt = '0;
                    w_rem_nxt  = r_remaining - 5'd1;
                    if (r_remaining == 5'd1) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
            default: begin
                if (mode != MODE_FREEZE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // FSM, divider and burst registers; busy is registered from the next
    // state so it lines up with the state output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_adv       <= 1'b0;
            r_tick      <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == ST_BURST);
            r_adv       <= w_adv_nxt;
            r_tick      <= w_tick_nxt;
            r_remaining <= w_rem_nxt;
        end
    end

    // Valid shift and step count follow the pipeline registers, which
    // capture on the edge that ends an adv cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_step_cnt <= '0;
        end else if (r_adv) begin
            r_v1       <= load_valid;
            r_v2       <= r_v1;
            r_step_cnt <= r_step_cnt + 8'd1;
        end
    end

    assign adv      = r_adv;
    assign v1       = r_v1;
    assign v2       = r_v2;
    assign step_cnt = r_step_cnt;
    assign busy     = r_busy;
    assign state    = r_state;

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Bench for pipe_step_ctrl with short debounce and divider settings.
module tb_pipe_step_ctrl;

    localparam int DBC  = 4;
    localparam int ADIV = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_n = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] burst_len = 4'd0;
    logic       load_valid = 1'b0;
    logic       adv;
    logic       v1;
    logic       v2;
    logic [7:0] step_cnt;
    logic       busy;
    logic [1:0] state;

    pipe_step_ctrl #(
        .DEBOUNCE_CYCLES (DBC),
        .AUTO_DIV        (ADIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .mode       (mode),
        .burst_len  (burst_len),
        .load_valid (load_valid),
        .adv        (adv),
        .v1         (v1),
        .v2         (v2),
        .step_cnt   (step_cnt),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int vec_cnt = 0;
    int miss = 0;
    int adv_total = 0;
    int last_adv_cyc = -1;

    always @(posedge clk) cyc++;

    // Reference model. The key path is judged on raw key history: the
    // debounced level flips at edge e when the synchronized samples seen at
    // edges e-DBC..e (raw key at edges e-2-DBC..e-2) all disagree with it.
    int hist[$];
    bit pflip[$];
    bit m_db;
    int m_st, m_left, m_rem, m_cnt;
    bit m_adv, m_v1, m_v2;

    function automatic int raw(input int i);
        if (i < 0) return 1;
        return hist[i];
    endfunction

    always @(posedge clk or negedge rst) begin
        int e;
        bit prs, flip, nadv;
        if (!rst) begin
            hist.delete();
            pflip.delete();
            m_db = 1'b1;
            m_st = 0; m_left = 0; m_rem = 0; m_cnt = 0;
            m_adv = 1'b0; m_v1 = 1'b0; m_v2 = 1'b0;
        end else begin
            hist.push_back(int'(key_n));
            e = hist.size() - 1;
            prs = (e >= 2) ? pflip[e-2] : 1'b0;
            flip = 1'b1;
            for (int j = 0; j <= DBC; j++)
                if (raw(e - 2 - j) == int'(m_db)) flip = 1'b0;
            if (flip) m_db = !m_db;
            pflip.push_back(flip && !m_db);
            if (m_adv) begin
                m_v2 = m_v1;
                m_v1 = load_valid;
                m_cnt = (m_cnt + 1) % 256;
            end
            nadv = 1'b0;
            case (m_st)
                0: begin
                    if (mode == 2'd1) begin m_st = 1; m_left = ADIV - 1; end
                    else if (mode == 2'd3) m_st = 3;
                    else if (mode == 2'd0 && prs) nadv = 1'b1;
                    else if (mode == 2'd2 && prs) begin
                        m_st = 2;
                        m_rem = (burst_len == 4'd0) ? 16 : int'(burst_len);
                        m_left = ADIV - 1;
                    end
                end
                1: begin
                    if (mode != 2'd1) m_st = 0;
                    else if (m_left == 0) begin nadv = 1'b1; m_left = ADIV - 1; end
                    else m_left--;
                end
                2: begin
                    if (mode != 2'd2) m_st = 0;
                    else if (m_left == 0) begin
                        nadv = 1'b1;
                        m_left = ADIV - 1;
                        m_rem--;
                        if (m_rem == 0) m_st = 0;
                    end else m_left--;
                end
                default: if (mode != 2'd3) m_st = 0;
            endcase
            m_adv = nadv;
        end
    end

    // Every-cycle comparison against the model, plus adv bookkeeping
    always @(negedge clk) begin
        logic [13:0] got, exp;
        got = {adv, v1, v2, step_cnt, busy, state};
        exp = {m_adv, m_v1, m_v2, 8'(m_cnt), (m_st == 2), 2'(m_st)};
        vec_cnt++;
        if (got !== exp) begin
            miss++;
            $display("FAIL cycle_model cyc=%0d dut adv=%b v1=%b v2=%b cnt=%0d busy=%b st=%0d, model adv=%b v1=%b v2=%b cnt=%0d busy=%b st=%0d",
                     cyc, adv, v1, v2, step_cnt, busy, state,
                     exp[13], exp[12], exp[11], exp[10:3], exp[2], exp[1:0]);
        end
        if (adv === 1'b1) begin
            adv_total++;
            last_adv_cyc = cyc;
        end
    end

    task automatic chk(input string name, input int got, input int expv);
        vec_cnt++;
        if (got != expv) begin
            miss++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic press_key(input int low, input int high);
        key_n = 1'b0;
        step(low);
        key_n = 1'b1;
        step(high);
    endtask

    task automatic wait_adv(input int target, input int budget, input string name);
        int k = 0;
        while (adv_total < target && k < budget) begin
            step(1);
            k++;
        end
        if (adv_total < target) chk(name, adv_total, target);
    endtask

    initial begin
        int t0, base, dur, len;

        // Reset values and manual step with leading bounces
        do_reset();
        chk("reset_step_cnt", step_cnt, 0);
        chk("reset_state", state, 0);
        mode = 2'b00;
        base = adv_total;
        repeat (2) begin
            key_n = 1'b0; step(3);
            key_n = 1'b1; step(3);
        end
        t0 = cyc;
        key_n = 1'b0; step(20);
        key_n = 1'b1; step(12);
        chk("manual_one_adv", adv_total - base, 1);
        chk("manual_latency", last_adv_cyc, t0 + 1 + 8);
        chk("manual_step_cnt", step_cnt, 1);

        // Valid flag shift
        load_valid = 1'b1;
        press_key(10, 12);
        chk("valid_v1_first", v1, 1);
        chk("valid_v2_first", v2, 0);
        press_key(10, 12);
        chk("valid_v2_second", v2, 1);
        press_key(10, 12);
        load_valid = 1'b0;
        press_key(10, 12);
        chk("valid_v1_drop", v1, 0);
        chk("valid_v2_hold", v2, 1);
        chk("valid_step_cnt", step_cnt, 5);

        // Auto mode, press ignored
        mode = 2'b01;
        t0 = cyc;
        base = adv_total;
        step(3);
        key_n = 1'b0; step(10);
        key_n = 1'b1; step(13);
        chk("auto_count", adv_total - base, 5);
        chk("auto_last_adv", last_adv_cyc, t0 + 1 + 25);
        mode = 2'b00;
        step(3);

        // Burst of 3, then burst_len 0 meaning 16
        mode = 2'b10;
        burst_len = 4'd3;
        step(2);
        base = adv_total;
        t0 = cyc;
        press_key(10, 35);
        chk("burst3_count", adv_total - base, 3);
        chk("burst3_last_adv", last_adv_cyc, t0 + 1 + 8 + 15);
        chk("burst3_state_idle", state, 0);
        burst_len = 4'd0;
        base = adv_total;
        press_key(10, 90);
        chk("burst16_count", adv_total - base, 16);
        chk("burst16_busy_low", busy, 0);

        // Burst of 8 frozen after the second step
        burst_len = 4'd8;
        base = adv_total;
        key_n = 1'b0;
        wait_adv(base + 2, 60, "burst8_second_adv");
        mode = 2'b11;
        step(6);
        key_n = 1'b1;
        step(20);
        chk("freeze_abort_count", adv_total - base, 2);
        chk("freeze_state", state, 3);
        chk("freeze_busy", busy, 0);
        mode = 2'b00;
        step(3);

        // Reset mid-burst
        mode = 2'b10;
        burst_len = 4'd8;
        load_valid = 1'b1;
        base = adv_total;
        key_n = 1'b0;
        wait_adv(base + 1, 40, "rstburst_first_adv");
        step(2);
        rst = 1'b0;
        #1;
        chk("rst_outputs", {adv, v1, v2, step_cnt, busy, state}, 0);
        key_n = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        chk("rst_no_adv_after_release", adv, 0);
        step(10);
        chk("rst_idle", state, 0);

        // Step counter wrap using auto mode
        mode = 2'b01;
        base = adv_total;
        wait_adv(base + 255, 255 * ADIV + 20, "wrap_255_adv");
        step(1);
        chk("wrap_cnt_255", step_cnt, 255);
        wait_adv(base + 256, 20, "wrap_256_adv");
        step(1);
        chk("wrap_cnt_0", step_cnt, 0);
        mode = 2'b00;
        step(3);

        // Randomized traffic against the model
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            mode = 2'($urandom_range(0, 3));
            burst_len = 4'($urandom_range(0, 15));
            dur = $urandom_range(20, 80);
            while (dur > 0) begin
                load_valid = 1'($urandom);
                key_n = 1'($urandom);
                len = $urandom_range(1, 12);
                step(len);
                dur -= len;
            end
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b0;
                step(1);
                rst = 1'b1;
            end
        end
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
        $finish;
    end

endmodule
